// File: rtl/sd_read_block.sv
// SPI-mode SD single-block (CMD17) reader streaming 512 bytes with a valid strobe.
// Define SD_BYTE_ADDR_EN for SDSC byte addressing (sector << 9); default is block addressing.
module sd_read_block #(
  parameter int R1_TIMEOUT    = 512,
  parameter int TOKEN_TIMEOUT = 65535
) (
  input  logic       SD_clk,
  input  logic       rst_n,
  input  logic       init_i,
  input  logic       rd_req,
  input  logic [31:0] sector_i,
  input  logic       SD_dataout,
  output logic       SD_cs,
  output logic       SD_datain,
  output logic       rd_busy,
  output logic       rd_done,
  output logic       rd_err,
  output logic [1:0] err_code,
  output logic [7:0] data_o,
  output logic       data_valid,
  output logic [8:0] byte_idx
);

  localparam int TW_A = $clog2(R1_TIMEOUT + 1);
  localparam int TW_B = $clog2(TOKEN_TIMEOUT + 1);
  localparam int TW   = (TW_A > TW_B) ? TW_A : TW_B;

  typedef enum logic [3:0] {
    IDLE, SEND_CMD, WAIT_R1, GET_R1, WAIT_TOKEN,
    READ_DATA, READ_CRC, TRAIL, DONE
  } state_t;

  state_t state, state_nx;

  logic [11:0]   cnt;
  logic [TW-1:0] tmo;
  logic [47:0]   cmd_sr;
  logic [6:0]    r1_sr;
  logic [6:0]    dat_sr;
  logic [31:0]   cmd_arg;
  logic          accept;
  logic          err_set;
  logic [1:0]    err_val;

`ifdef SD_BYTE_ADDR_EN
  assign cmd_arg = {sector_i[22:0], 9'd0};
`else
  assign cmd_arg = sector_i;
`endif

  assign accept = (state == IDLE) && rd_req && init_i;

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    err_val  = 2'b00;
    unique case (state)
      IDLE:
        if (rd_req && init_i) state_nx = SEND_CMD;
      SEND_CMD:
        if (cnt == 12'd47) state_nx = WAIT_R1;
      WAIT_R1:
        if (!SD_dataout) begin
          state_nx = GET_R1;
        end else if (tmo == TW'(R1_TIMEOUT)) begin
          state_nx = TRAIL;
          err_set  = 1'b1;
          err_val  = 2'b10;
        end
      GET_R1:
        if (cnt == 12'd6) begin
          if ({r1_sr, SD_dataout} != 8'h00) begin
            state_nx = TRAIL;
            err_set  = 1'b1;
            err_val  = 2'b01;
          end else begin
            state_nx = WAIT_TOKEN;
          end
        end
      WAIT_TOKEN:
        if (!SD_dataout) begin
          state_nx = READ_DATA;
        end else if (tmo == TW'(TOKEN_TIMEOUT)) begin
          state_nx = TRAIL;
          err_set  = 1'b1;
          err_val  = 2'b11;
        end
      READ_DATA:
        if (cnt == 12'd4095) state_nx = READ_CRC;
      READ_CRC:
        if (cnt == 12'd15) state_nx = TRAIL;
      TRAIL:
        if (cnt == 12'd7) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Both counters restart on every state change
  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tmo <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
      tmo <= '0;
    end else begin
      cnt <= cnt + 12'd1;
      tmo <= tmo + TW'(1);
    end
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sr <= '1;
      r1_sr  <= '0;
      dat_sr <= '0;
    end else begin
      if (accept)
        cmd_sr <= {8'h51, cmd_arg, 8'hFF};
      else if (state == SEND_CMD)
        cmd_sr <= {cmd_sr[46:0], 1'b1};
      if (state == WAIT_R1 || state == GET_R1)
        r1_sr <= {r1_sr[5:0], SD_dataout};
      if (state == READ_DATA)
        dat_sr <= {dat_sr[5:0], SD_dataout};
    end
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o     <= '0;
      data_valid <= 1'b0;
      byte_idx   <= '0;
    end else begin
      data_valid <= 1'b0;
      if (state == READ_DATA && cnt[2:0] == 3'd7) begin
        data_o     <= {dat_sr, SD_dataout};
        data_valid <= 1'b1;
        byte_idx   <= cnt[11:3];
      end
    end
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_code <= 2'b00;
      rd_err   <= 1'b0;
    end else begin
      if (accept) begin
        err_code <= 2'b00;
        rd_err   <= 1'b0;
      end else if (err_set) begin
        err_code <= err_val;
      end
      if (state == TRAIL && cnt == 12'd7)
        rd_err <= (err_code != 2'b00);
    end
  end

  assign SD_cs     = (state == IDLE) || (state == TRAIL) || (state == DONE);
  assign SD_datain = (state == SEND_CMD) ? cmd_sr[47] : 1'b1;
  assign rd_busy   = (state != IDLE);
  assign rd_done   = (state == DONE);

endmodule

// File: tb/tb_sd_read_block.sv
// Bench for sd_read_block: SPI card model feeding a byte scoreboard.
// Covers clean reads, R1 error, R1/token timeouts, ignored requests, mid-read reset.
module tb_sd_read_block;

  logic        SD_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_i = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        rd_req;
  logic [31:0] sector_i = '0;
  logic        SD_dataout = 1'b1;
  logic        SD_cs, SD_datain, rd_busy, rd_done, rd_err, data_valid;
  logic [1:0]  err_code;
  logic [7:0]  data_o;
  logic [8:0]  byte_idx;

  assign rd_req = req_a | req_b;

  always #5 SD_clk = ~SD_clk;

  sd_read_block #(
    .R1_TIMEOUT(512),
    .TOKEN_TIMEOUT(200)
  ) dut (
    .SD_clk(SD_clk), .rst_n(rst_n), .init_i(init_i), .rd_req(rd_req),
    .sector_i(sector_i), .SD_dataout(SD_dataout), .SD_cs(SD_cs),
    .SD_datain(SD_datain), .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_err(rd_err), .err_code(err_code), .data_o(data_o),
    .data_valid(data_valid), .byte_idx(byte_idx)
  );

  // Clean read: 48 cmd + 16 idle + 8 R1 + (100 idle + 8 token) + 4096 + 16 CRC + 8 trail,
  // minus one because the card's first response bit lands on the last command edge.
  localparam int CLEAN_LAT = 48 + 16 + 8 + (100 + 8) + 4096 + 16 + 8 - 1;

  typedef struct {
    logic [7:0] d;
    logic [8:0] i;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;
  int   ncmd = 0;
  int   cmds = 0;
  int   strobes = 0;
  int   last_sb = 0;
  int   hi_run = 0;
  bit   poke = 1'b0;
  bit   miso_q[$];
  exp_t exp_q[$];
  exp_t e;
  logic [47:0] cmd_got = '0;
  logic [47:0] exp_cmd = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_ones(input int n);
    for (int k = 0; k < n; k++) miso_q.push_back(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) miso_q.push_back(b[k]);
  endtask

  task automatic build_stream();
    case (mode)
      0: begin
        push_ones(16);
        push_byte(8'h00);
        push_ones(100);
        push_byte(8'hFE);
        for (int i = 0; i < 512; i++) begin
          push_byte(8'(i));
          exp_q.push_back('{8'(i), 9'(i)});
        end
        push_ones(16);
      end
      1: begin
        push_ones(16);
        push_byte(8'h04);
      end
      3: begin
        push_ones(16);
        push_byte(8'h00);
      end
      default: ;
    endcase
  endtask

  always @(posedge SD_clk) cyc++;

  // Card model: collect the command while selected, then replay the response
  always @(negedge SD_clk) begin
    if (SD_cs) begin
      ncmd = 0;
      miso_q.delete();
      SD_dataout = 1'b1;
    end else begin
      if (ncmd < 48) begin
        cmd_got = {cmd_got[46:0], SD_datain};
        ncmd++;
        if (ncmd == 48) begin
          cmds++;
          check("cmd", cmd_got, exp_cmd);
          build_stream();
        end
      end
      if (miso_q.size() > 0) SD_dataout = miso_q.pop_front();
      else SD_dataout = 1'b1;
    end
  end

  always @(negedge SD_clk) begin
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data", data_o, e.d);
        check("idx", byte_idx, e.i);
      end
      if (strobes > 0) check("gap", cyc - last_sb, 8);
      strobes++;
      last_sb = cyc;
    end
    if (rd_done) check("cs_trail", hi_run, 8);
    hi_run = SD_cs ? hi_run + 1 : 0;
  end

  always @(negedge SD_clk) req_b = poke && (strobes == 50);

  task automatic set_cmd(input logic [31:0] sec);
    sector_i = sec;
`ifdef SD_BYTE_ADDR_EN
    exp_cmd = {8'h51, sec << 9, 8'hFF};
`else
    exp_cmd = {8'h51, sec, 8'hFF};
`endif
  endtask

  task automatic do_read(input logic [31:0] sec, input int m,
                         input logic [1:0] code, input int nstb,
                         input int lat);
    int t0;
    int n;
    int c0;
    mode = m;
    set_cmd(sec);
    strobes = 0;
    c0 = cmds;
    @(negedge SD_clk);
    req_a = 1'b1;
    @(negedge SD_clk);
    req_a = 1'b0;
    t0 = cyc;
    check("busy", rd_busy, 1);
    check("cs_low", SD_cs, 0);
    n = 0;
    while (!rd_done && n < 12000) begin
      @(negedge SD_clk);
      n++;
    end
    check("done_seen", rd_done, 1);
    if (lat > 0) check("latency", cyc - t0, lat);
    check("rd_err", rd_err, code != 2'b00);
    check("err_code", err_code, code);
    check("strobes", strobes, nstb);
    check("q_empty", exp_q.size(), 0);
    check("one_cmd", cmds - c0, 1);
    @(negedge SD_clk);
    check("busy_after", rd_busy, 0);
    check("err_hold", err_code, code);
    check("rderr_hold", rd_err, code != 2'b00);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"}, SD_cs, 1);
    check({tag, "_mosi"}, SD_datain, 1);
    check({tag, "_busy"}, rd_busy, 0);
    check({tag, "_done"}, rd_done, 0);
    check({tag, "_err"}, rd_err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_idx"}, byte_idx, 0);
  endtask

  initial begin
    int n;
    int c0;
    repeat (3) @(negedge SD_clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge SD_clk);

    c0 = cmds;
    set_cmd(32'h1);
    req_a = 1'b1;
    @(negedge SD_clk);
    req_a = 1'b0;
    repeat (5) @(negedge SD_clk);
    check("noinit_busy", rd_busy, 0);
    check("noinit_cs", SD_cs, 1);
    check("noinit_cmd", cmds - c0, 0);

    init_i = 1'b1;
    poke = 1'b1;
    do_read(32'h0000_0010, 0, 2'b00, 512, CLEAN_LAT);
    poke = 1'b0;
    do_read(32'h0000_0020, 1, 2'b01, 0, 0);
    do_read(32'h0000_0030, 2, 2'b10, 0, 0);
    do_read(32'h0000_0040, 3, 2'b11, 0, 0);

    mode = 0;
    set_cmd(32'h0000_0050);
    strobes = 0;
    @(negedge SD_clk);
    req_a = 1'b1;
    @(negedge SD_clk);
    req_a = 1'b0;
    n = 0;
    while (!(data_valid && byte_idx == 9'd100) && n < 3000) begin
      @(negedge SD_clk);
      n++;
    end
    check("reach100", byte_idx, 100);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    exp_q.delete();
    repeat (3) @(negedge SD_clk);
    rst_n = 1'b1;
    @(negedge SD_clk);
    do_read(32'h1234_5678, 0, 2'b00, 512, CLEAN_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
